ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device transmitter for the PS/2 port. It sends command bytes such as 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset) to the keyboard on the same ps2_clk/ps2_data pair that the existing ps2_keyboard receiver listens on. It drives both lines open-drain: it only ever pulls a line low or releases it. It owns the inhibit/request-to-send sequence, shifts out the frame on device-generated clocks, and checks the device acknowledge. While the block is busy, the receiver must ignore the bus.

## Interface
Parameters:
- INHIBIT_CYCLES, default 5000: clk cycles ps2_clk is held low before the request (≥100 µs at 50 MHz).
- REQ_CYCLES, default 10: clk cycles both lines are held low before ps2_clk is released.
- TIMEOUT_CYCLES, default 100000: maximum clk cycles allowed between device clock falling edges.

Ports:
- clk  in  1  system clock; the only clock.
- clrn  in  1  reset, asynchronous, active-low.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  block idle; a byte is accepted on tx_valid & tx_ready.
- ps2_clk_in  in  1  sampled ps2_clk pin, asynchronous.
- ps2_data_in  in  1  sampled ps2_data pin, asynchronous.
- ps2_clk_low  out  1  1 = pull ps2_clk low; 0 = release.
- ps2_data_low  out  1  1 = pull ps2_data low; 0 = release.
- busy  out  1  transmission in progress; the receiver ignores the bus while this is high.
- done  out  1  one-cycle pulse when the device acknowledges.
- ack_err  out  1  one-cycle pulse when the ACK bit is sampled high.
- timeout  out  1  one-cycle pulse when the transfer is aborted on timeout.

## Operation
- **Synchronizer:** each PS/2 input passes through 3 flops, which reset to 1.
  - fall = s[2] & ~s[1].
- **Frame:** frame[9:0] = {1'b1 stop, parity, tx_data}.
  - parity = ~^tx_data (odd parity).
  - frame is latched on accept.
  - bit_cnt is a 4-bit counter, cleared on accept.
- **State machine:**
  - **IDLE:** tx_ready=1, both lines released. On tx_valid: latch the frame, load the counter, go to INHIBIT.
  - **INHIBIT:** ps2_clk_low=1, ps2_data_low=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - **REQ:** ps2_clk_low=1, ps2_data_low=1 (start bit) for exactly REQ_CYCLES cycles, then go to SHIFT.
  - **SHIFT:** ps2_clk_low=0, start bit still driven. Each fall while bit_cnt<10 does: ps2_data_low <= ~frame[bit_cnt]; bit_cnt++.
    - Falls 1–8 carry data bits 0–7, LSB first.
    - Fall 9 carries parity.
    - Fall 10 carries stop, which releases the line. Then go to ACK.
  - **ACK:** on the next fall, sample s[1] of the data line.
    - 0: pulse done.
    - 1: pulse ack_err.
    - Either way, go to WAIT_IDLE.
  - **WAIT_IDLE:** both lines released. Go to IDLE once both synchronized lines are high.
- **Timeout:** a watchdog counter is cleared on entry to SHIFT and on every fall. If it reaches TIMEOUT_CYCLES in SHIFT or ACK:
  - release both lines;
  - pulse timeout;
  - go to IDLE.
- **busy:** busy = (state != IDLE).
- **tx_valid while not IDLE:** ignored. The byte is not queued.

## Timing
- **Reset values:** tx_ready=1, busy=0, ps2_clk_low=0, ps2_data_low=0, done=0, ack_err=0, timeout=0. State is IDLE.
- **Reset mid-transfer:** both lines are released asynchronously, and the frame is abandoned.
- **All outputs are registered.**
  - tx_ready falls in the cycle after accept.
  - ps2_clk_low rises in that same cycle.
- **Inhibit phase:** ps2_clk_low is high for INHIBIT_CYCLES + REQ_CYCLES cycles. The ps2_data_low rise trails the ps2_clk_low rise by exactly INHIBIT_CYCLES cycles.
- **Edge latency:** a falling edge on the ps2_clk pin is detected 2–3 clk cycles later. The next data bit appears on ps2_data_low in the following cycle, well inside the ~30 µs low half-period of the device clock.
- **done / ack_err / timeout:** each is high for exactly one cycle and they are mutually exclusive. After any of them, tx_ready returns no earlier than the cycle after both lines are seen high.
- **Falls outside SHIFT and ACK are ignored.** This includes glitches seen during INHIBIT or REQ, where the host itself holds the clock low.

## Test plan
- Reset held low with tx_valid=1 → tx_ready=1, both *_low=0, no pulses. After release, the byte is accepted on the first edge.
- Send 0xED; the device model clocks 11 falls and drives ACK low → data line driven (released=1) as 0 (start), then 1,0,1,1,0,1,1,1, then parity 1, then stop 1. done pulses once, tx_ready returns.
- Send 0x00 and 0x01 → parity bits are 1 and 0 respectively. The device model checks odd parity on each byte.
- Device leaves ps2_data high at ACK → ack_err pulses once, done stays 0, the block returns to IDLE.
- Device stops clocking after 4 falls → after TIMEOUT_CYCLES (set to 200 in the bench), timeout pulses, both lines are released, tx_ready=1.
- clrn asserted during SHIFT at bit 5 → both *_low drop to 0 immediately. After release, a new 0xF4 send completes with done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit/request-to-send, frame shift on device clocks,
// acknowledge check and a watchdog, driving both lines open-drain through *_low outputs.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       clrn_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       ps2_clk_in_i,
  input  logic       ps2_data_in_i,
  output logic       ps2_clk_low_o,
  output logic       ps2_data_low_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic       timeout_o
);

  localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0] REQ_LAST = PH_W'(REQ_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      clkSync_q, dataSync_q;
  logic [9:0]      frame_q, frame_d;
  logic [3:0]      bitCnt_q, bitCnt_d;
  logic [PH_W-1:0] phaseCnt_q, phaseCnt_d;
  logic [WD_W-1:0] wdCnt_q, wdCnt_d;
  logic            clkLow_q, clkLow_d;
  logic            dataLow_q, dataLow_d;
  logic            txReady_q, txReady_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ackErr_q, ackErr_d;
  logic            timeout_q, timeout_d;
  logic            fall;

  // Pins idle high, so the synchronizers reset to 1 to avoid a false fall after reset.
  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      clkSync_q  <= 3'b111;
      dataSync_q <= 3'b111;
    end else begin
      clkSync_q  <= {clkSync_q[1:0], ps2_clk_in_i};
      dataSync_q <= {dataSync_q[1:0], ps2_data_in_i};
    end
  end

  assign fall = clkSync_q[2] & ~clkSync_q[1];

  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      bitCnt_q   <= '0;
      phaseCnt_q <= '0;
      wdCnt_q    <= '0;
      clkLow_q   <= 1'b0;
      dataLow_q  <= 1'b0;
      txReady_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ackErr_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bitCnt_q   <= bitCnt_d;
      phaseCnt_q <= phaseCnt_d;
      wdCnt_q    <= wdCnt_d;
      clkLow_q   <= clkLow_d;
      dataLow_q  <= dataLow_d;
      txReady_q  <= txReady_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ackErr_q   <= ackErr_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bitCnt_d   = bitCnt_q;
    phaseCnt_d = phaseCnt_q;
    wdCnt_d    = wdCnt_q;
    clkLow_d   = clkLow_q;
    dataLow_d  = dataLow_q;
    done_d     = 1'b0;
    ackErr_d   = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        clkLow_d  = 1'b0;
        dataLow_d = 1'b0;
        if (tx_valid_i) begin
          frame_d    = {1'b1, ~^tx_data_i, tx_data_i};
          bitCnt_d   = '0;
          phaseCnt_d = '0;
          clkLow_d   = 1'b1;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (phaseCnt_q == INH_LAST) begin
          phaseCnt_d = '0;
          dataLow_d  = 1'b1;
          state_d    = REQ;
        end else begin
          phaseCnt_d = phaseCnt_q + 1'b1;
        end
      end
      REQ: begin
        if (phaseCnt_q == REQ_LAST) begin
          clkLow_d = 1'b0;
          wdCnt_d  = '0;
          state_d  = SHIFT;
        end else begin
          phaseCnt_d = phaseCnt_q + 1'b1;
        end
      end
      SHIFT: begin
        // Each device clock fall presents the next frame bit; the stop bit releases the line.
        if (fall) begin
          wdCnt_d = '0;
          if (bitCnt_q < 4'd10) begin
            dataLow_d = ~frame_q[bitCnt_q];
            bitCnt_d  = bitCnt_q + 1'b1;
            if (bitCnt_q == 4'd9) begin
              state_d = ACK;
            end
          end
        end else if (wdCnt_q == WD_LAST) begin
          timeout_d = 1'b1;
        end else begin
          wdCnt_d = wdCnt_q + 1'b1;
        end
      end
      ACK: begin
        if (fall) begin
          wdCnt_d = '0;
          if (dataSync_q[1]) begin
            ackErr_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
          state_d = WAIT_IDLE;
        end else if (wdCnt_q == WD_LAST) begin
          timeout_d = 1'b1;
        end else begin
          wdCnt_d = wdCnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        clkLow_d  = 1'b0;
        dataLow_d = 1'b0;
        if ((&clkSync_q[2:1]) && (&dataSync_q[2:1])) begin
          state_d = IDLE;
        end
      end
      default: begin
        clkLow_d  = 1'b0;
        dataLow_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    // A stalled device aborts the frame straight back to idle with the bus released.
    if (timeout_d) begin
      clkLow_d  = 1'b0;
      dataLow_d = 1'b0;
      state_d   = IDLE;
    end

    txReady_d = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
  end

  assign tx_ready_o     = txReady_q;
  assign ps2_clk_low_o  = clkLow_q;
  assign ps2_data_low_o = dataLow_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign ack_err_o      = ackErr_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of the host
// and compares every bit and status pulse against a frame model built from the byte.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int REQ = 5;
  localparam int TO  = 200;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       txValid = 1'b0;
  logic       txReady, ps2ClkLow, ps2DataLow, busy, done, ackErr, timeout;
  logic       devClkLow = 1'b0;
  logic       devDataLow = 1'b0;
  wire        ps2ClkPin  = ~(ps2ClkLow | devClkLow);
  wire        ps2DataPin = ~(ps2DataLow | devDataLow);

  int checks = 0;
  int failures = 0;
  int doneSeen = 0;
  int errSeen = 0;
  int toSeen = 0;
  logic prevPulse = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         falls;
    bit         ackLow;
    int         resetAt;
    bit         expDone;
    bit         expErr;
    bit         expTimeout;
  } vec_t;

  vec_t vecs[13];

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .clrn_i(clrn), .tx_data_i(txData), .tx_valid_i(txValid),
    .tx_ready_o(txReady), .ps2_clk_in_i(ps2ClkPin), .ps2_data_in_i(ps2DataPin),
    .ps2_clk_low_o(ps2ClkLow), .ps2_data_low_o(ps2DataLow), .busy_o(busy),
    .done_o(done), .ack_err_o(ackErr), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL global time limit: simulation did not finish, required finish");
    $fatal(1, "[TB] global time limit");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Status pulses: counted, one cycle wide and never two at once.
  always @(negedge clk) begin
    if (done) doneSeen++;
    if (ackErr) errSeen++;
    if (timeout) toSeen++;
    if (done | ackErr | timeout) begin
      checks++;
      if ((int'(done) + int'(ackErr) + int'(timeout)) != 1 || prevPulse) begin
        failures++;
        $display("[TB] FAIL pulse shape: done=%0b ack_err=%0b timeout=%0b prev=%0b, expected single one-cycle pulse",
                 done, ackErr, timeout, prevPulse);
      end
    end
    prevPulse = done | ackErr | timeout;
  end

  // Line level the device should see for frame position k (0 = start ... 10 = stop).
  function automatic bit expectedBit(input logic [7:0] d, input int k);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9) return (ones % 2 == 0);
    return 1'b1;
  endfunction

  task automatic applyStimulus(input vec_t v);
    int waited, n, m, ones, lastFall, d0, e0, t0;
    bit got;
    waited = 0;
    while (!txReady && waited < 100) begin tick(); waited++; end
    checkOutput("ready before send", txReady, 1);
    d0 = doneSeen; e0 = errSeen; t0 = toSeen;

    txData = v.data;
    txValid = 1'b1;
    tick();
    checkOutput("tx_ready after accept", txReady, 0);
    checkOutput("clk low after accept", ps2ClkLow, 1);
    checkOutput("busy after accept", busy, 1);
    // Keep a different byte offered while busy; it must never be sent.
    txData = ~v.data;
    n = 1;
    while (n < 1000) begin
      tick();
      if (n == 3) txValid = 1'b0;
      if (!(ps2ClkLow && !ps2DataLow)) break;
      n++;
    end
    txValid = 1'b0;
    checkOutput("inhibit length", n, INH);
    checkOutput("data low after inhibit", ps2DataLow, 1);
    checkOutput("clk low during request", ps2ClkLow, 1);
    m = 1;
    while (m < 1000) begin
      tick();
      if (!(ps2ClkLow && ps2DataLow)) break;
      m++;
    end
    checkOutput("request length", m, REQ);
    checkOutput("clk released for shift", ps2ClkLow, 0);
    checkOutput("start bit", !ps2DataLow, expectedBit(v.data, 0));

    ones = 0;
    lastFall = (v.falls > 10) ? 10 : v.falls;
    for (int k = 1; k <= lastFall; k++) begin
      repeat (6) tick();
      devClkLow = 1'b1;
      repeat (6) tick();
      got = !ps2DataLow;
      checkOutput($sformatf("frame bit %0d of byte %02h", k, v.data), got, expectedBit(v.data, k));
      if (k <= 9) ones += int'(got);
      if (v.resetAt == k) begin
        #3 clrn = 1'b0;
        #1;
        checkOutput("clk released by reset", ps2ClkLow, 0);
        checkOutput("data released by reset", ps2DataLow, 0);
        checkOutput("ready during reset", txReady, 1);
        #2 devClkLow = 1'b0;
        repeat (3) tick();
        clrn = 1'b1;
        tick();
        return;
      end
      devClkLow = 1'b0;
    end
    if (lastFall == 10) checkOutput($sformatf("odd parity on %02h", v.data), ones % 2, 1);

    if (v.falls >= 11) begin
      repeat (6) tick();
      devDataLow = v.ackLow;
      tick();
      devClkLow = 1'b1;
      repeat (8) tick();
      devClkLow = 1'b0;
      devDataLow = 1'b0;
      waited = 0;
      while (!txReady && waited < 100) begin tick(); waited++; end
      checkOutput("ready after ack", txReady, 1);
    end else begin
      waited = 0;
      while (!timeout && waited < TO + 50) begin tick(); waited++; end
      checkOutput("timeout pulse seen", timeout, 1);
      checkOutput("timeout latency in range", (waited >= TO - 20) && (waited <= TO + 5), 1);
      checkOutput("clk released on timeout", ps2ClkLow, 0);
      checkOutput("data released on timeout", ps2DataLow, 0);
      checkOutput("ready on timeout", txReady, 1);
    end
    repeat (5) tick();
    checkOutput($sformatf("done count %02h", v.data), doneSeen - d0, v.expDone);
    checkOutput($sformatf("ack_err count %02h", v.data), errSeen - e0, v.expErr);
    checkOutput($sformatf("timeout count %02h", v.data), toSeen - t0, v.expTimeout);
    checkOutput("busy byte not queued", busy, 0);
  endtask

  initial begin
    vecs[0] = '{8'hED, 11, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 11, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h01, 11, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 11, 1'b0, 0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'hAA, 4,  1'b1, 0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'hF4, 11, 1'b1, 5, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'hF4, 11, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    for (int i = 7; i < 13; i++) begin
      vecs[i].data       = 8'($urandom_range(0, 255));
      vecs[i].falls      = 11;
      vecs[i].ackLow     = 1'($urandom_range(0, 1));
      vecs[i].resetAt    = 0;
      vecs[i].expDone    = vecs[i].ackLow;
      vecs[i].expErr     = !vecs[i].ackLow;
      vecs[i].expTimeout = 1'b0;
    end

    // Reset held with a request pending: idle outputs, then accept on the first edge.
    clrn = 1'b0;
    txValid = 1'b1;
    txData = 8'hED;
    repeat (3) tick();
    checkOutput("reset tx_ready", txReady, 1);
    checkOutput("reset clk_low", ps2ClkLow, 0);
    checkOutput("reset data_low", ps2DataLow, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset pulses", {done, ackErr, timeout}, 0);
    clrn = 1'b1;
    tick();
    checkOutput("accept first edge after reset", txReady, 0);
    checkOutput("clk low first edge after reset", ps2ClkLow, 1);
    txValid = 1'b0;
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      $display("[TB] vector %0d: byte %02h falls %0d ack_low %0b reset_at %0d",
               i, vecs[i].data, vecs[i].falls, vecs[i].ackLow, vecs[i].resetAt);
      applyStimulus(vecs[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
